// File: rtl/conv1_window_gen_if.sv
// Pixel-stream-in / window-out bundle between the frame source, conv1_window_gen and conv1.
// The slave modport is the window generator's view; master is the source/consumer side.
interface conv1_window_gen_if #(
    parameter int CH = 3,
    parameter int DW = 16
);
    logic                   in_valid;
    logic                   sof;
    logic [CH*DW-1:0]       in_pixel;
    logic                   out_valid;
    logic [9*CH*DW-1:0]     out_window;
    logic                   frame_done;

    modport master (
        output in_valid, sof, in_pixel,
        input  out_valid, out_window, frame_done
    );

    modport slave (
        input  in_valid, sof, in_pixel,
        output out_valid, out_window, frame_done
    );
endinterface

// File: rtl/conv1_window_gen.sv
// 3x3 sliding-window generator feeding conv1: buffers two image lines and emits one
// packed 432-bit window per accepted pixel whose 3x3 neighbourhood lies fully inside the frame.
module conv1_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int CH    = 3,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rstn,
    conv1_window_gen_if.slave  bus
);
    localparam int PW = CH * DW;
    localparam int WW = 9 * PW;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col, eff_col, nxt_col;
    logic [RW-1:0] row, eff_row, nxt_row;
    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] win [9];
    logic [PW-1:0] nxt_win [9];
    logic [WW-1:0] packed_win;
    logic [WW-1:0] window_q;
    logic          emit, last;
    logic          valid_q, done_q;

    // sof forces the position to (0,0) before the pixel is processed.
    always_comb begin
        eff_col = col;
        eff_row = row;
        if (bus.sof) begin
            eff_col = '0;
            eff_row = '0;
        end

        for (int r = 0; r < 3; r++) begin
            nxt_win[3*r]     = win[3*r+1];
            nxt_win[3*r+1]   = win[3*r+2];
        end
        nxt_win[2] = lb1[eff_col];
        nxt_win[5] = lb0[eff_col];
        nxt_win[8] = bus.in_pixel;

        emit = bus.in_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
        last = (eff_row == RW'(IMG_H-1)) && (eff_col == CW'(IMG_W-1));

        nxt_col = eff_col + CW'(1);
        nxt_row = eff_row;
        if (eff_col == CW'(IMG_W-1)) begin
            nxt_col = '0;
            nxt_row = (eff_row == RW'(IMG_H-1)) ? '0 : eff_row + RW'(1);
        end

        packed_win = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 9; k++) begin
                packed_win[9*DW*c + DW*k +: DW] = nxt_win[k][DW*c +: DW];
            end
        end
    end

    // The output register is separate from the window so it only moves on emitted windows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col      <= '0;
            row      <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            window_q <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else begin
            valid_q <= emit;
            done_q  <= emit && last;
            if (bus.in_valid) begin
                col          <= nxt_col;
                row          <= nxt_row;
                lb1[eff_col] <= lb0[eff_col];
                lb0[eff_col] <= bus.in_pixel;
                for (int k = 0; k < 9; k++) begin
                    win[k] <= nxt_win[k];
                end
                if (emit) begin
                    window_q <= packed_win;
                end
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.frame_done = done_q;
    assign bus.out_window = window_q;
endmodule

// File: tb/tb_conv1_window_gen.sv
// Self-checking bench for conv1_window_gen on a 4x4 image: an image-array reference model
// predicts every window, and each scenario task compares the captured windows against it.
module tb_conv1_window_gen;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CH = 3;
    localparam int DW = 16;
    localparam int PW = CH * DW;
    localparam int WW = 9 * PW;

    typedef struct {
        logic [WW-1:0] win;
        logic          fd;
    } win_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    conv1_window_gen_if #(.CH(CH), .DW(DW)) bus ();

    conv1_window_gen #(.IMG_W(W), .IMG_H(H), .CH(CH), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [PW-1:0] img [H][W];
    int   mr = 0;
    int   mc = 0;
    win_t exp_q[$];
    win_t obs_q[$];

    // Capture every emitted window half a cycle after the edge that produced it.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            win_t o;
            o.win = bus.out_window;
            o.fd  = bus.frame_done;
            obs_q.push_back(o);
        end
    end

    function automatic logic [PW-1:0] pix_of(input int r, input int c);
        return {16'(512 + 4*r + c), 16'(256 + 4*r + c), 16'(4*r + c)};
    endfunction

    function automatic logic [PW-1:0] rand_pix();
        return {16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    // Reference: store the pixel in a full image array and cut the window straight out of it.
    function automatic void model_accept(input logic s, input logic [PW-1:0] p);
        win_t w;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            w.win = '0;
            for (int ch = 0; ch < CH; ch++) begin
                for (int k = 0; k < 9; k++) begin
                    w.win[9*DW*ch + DW*k +: DW] = img[mr-2+k/3][mc-2+k%3][DW*ch +: DW];
                end
            end
            w.fd = (mr == H-1) && (mc == W-1);
            exp_q.push_back(w);
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endfunction

    task automatic step(input logic v, input logic s, input logic [PW-1:0] p);
        @(negedge clk);
        bus.in_valid = v;
        bus.sof      = s;
        bus.in_pixel = p;
        if (v) model_accept(s, p);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        bus.in_pixel = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.frame_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_frame_done: got %b want 0", bus.frame_done);
        end
        n_cmp++;
        if (bus.out_window !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_out_window: got %h want 0", bus.out_window);
        end
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_full_frame();
        int ch0_taps [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int ch1_taps [9] = '{261, 262, 263, 265, 266, 267, 269, 270, 271};
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, pix_of(i / W, i % W));
        idle(3);
        n_cmp++;
        if (obs_q.size() !== 4) begin
            n_err++;
            $display("[TB] FAIL full_count: got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].win !== exp_q[i].win) begin
                n_err++;
                $display("[TB] FAIL full_win%0d: got %h want %h", i, obs_q[i].win, exp_q[i].win);
            end
            n_cmp++;
            if (obs_q[i].fd !== exp_q[i].fd) begin
                n_err++;
                $display("[TB] FAIL full_done%0d: got %b want %b", i, obs_q[i].fd, exp_q[i].fd);
            end
        end
        if (obs_q.size() == 4) begin
            for (int k = 0; k < 9; k++) begin
                n_cmp++;
                if (obs_q[0].win[DW*k +: DW] !== 16'(ch0_taps[k])) begin
                    n_err++;
                    $display("[TB] FAIL first_ch0_k%0d: got %0d want %0d", k, obs_q[0].win[DW*k +: DW], ch0_taps[k]);
                end
                n_cmp++;
                if (obs_q[3].win[9*DW + DW*k +: DW] !== 16'(ch1_taps[k])) begin
                    n_err++;
                    $display("[TB] FAIL last_ch1_k%0d: got %0d want %0d", k, obs_q[3].win[9*DW + DW*k +: DW], ch1_taps[k]);
                end
            end
            n_cmp++;
            if (obs_q[0].win[18*DW + 8*DW +: DW] !== 16'd522) begin
                n_err++;
                $display("[TB] FAIL first_ch2_k8: got %0d want 522", obs_q[0].win[18*DW + 8*DW +: DW]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [WW-1:0] held;
        exp_q.delete();
        obs_q.delete();
        held = bus.out_window;
        for (int i = 0; i < W*H; i++) begin
            while ($urandom_range(0, 1) == 0) begin
                step(1'b0, 1'($urandom_range(0, 1)), rand_pix());
                n_cmp++;
                if (bus.out_valid === 1'b0 && bus.out_window !== held) begin
                    n_err++;
                    $display("[TB] FAIL gap_hold: got %h want %h", bus.out_window, held);
                end
                if (bus.out_valid === 1'b1) held = bus.out_window;
            end
            step(1'b1, i == 0, pix_of(i / W, i % W));
            if (bus.out_valid === 1'b1) held = bus.out_window;
        end
        idle(3);
        n_cmp++;
        if (obs_q.size() !== 4) begin
            n_err++;
            $display("[TB] FAIL gap_count: got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].win !== exp_q[i].win || obs_q[i].fd !== exp_q[i].fd) begin
                n_err++;
                $display("[TB] FAIL gap_win%0d: got %h/%b want %h/%b", i, obs_q[i].win, obs_q[i].fd, exp_q[i].win, exp_q[i].fd);
            end
        end
    endtask

    task automatic test_mid_sof();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 2*W + 1; i++) step(1'b1, i == 0, rand_pix());
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, pix_of(i / W, i % W));
        idle(3);
        n_cmp++;
        if (obs_q.size() !== 4) begin
            n_err++;
            $display("[TB] FAIL midsof_count: got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].win !== exp_q[i].win || obs_q[i].fd !== exp_q[i].fd) begin
                n_err++;
                $display("[TB] FAIL midsof_win%0d: got %h/%b want %h/%b", i, obs_q[i].win, obs_q[i].fd, exp_q[i].win, exp_q[i].fd);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 2*W + 3; i++) step(1'b1, i == 0, pix_of(i / W, i % W));
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL prereset_valid: got %b want 1", bus.out_valid);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_flags: got %b/%b want 0/0", bus.out_valid, bus.frame_done);
        end
        n_cmp++;
        if (bus.out_window !== '0) begin
            n_err++;
            $display("[TB] FAIL async_window: got %h want 0", bus.out_window);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rstn = 1'b1;
        mr = 0;
        mc = 0;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, rand_pix());
        idle(3);
        n_cmp++;
        if (obs_q.size() !== 4) begin
            n_err++;
            $display("[TB] FAIL postreset_count: got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].win !== exp_q[i].win || obs_q[i].fd !== exp_q[i].fd) begin
                n_err++;
                $display("[TB] FAIL postreset_win%0d: got %h/%b want %h/%b", i, obs_q[i].win, obs_q[i].fd, exp_q[i].win, exp_q[i].fd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fd_count;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 2*W*H; i++) step(1'b1, i == 0, rand_pix());
        idle(3);
        fd_count = 0;
        foreach (obs_q[i]) if (obs_q[i].fd === 1'b1) fd_count++;
        n_cmp++;
        if (obs_q.size() !== 8) begin
            n_err++;
            $display("[TB] FAIL b2b_count: got %0d want 8", obs_q.size());
        end
        n_cmp++;
        if (fd_count !== 2) begin
            n_err++;
            $display("[TB] FAIL b2b_done_count: got %0d want 2", fd_count);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].win !== exp_q[i].win || obs_q[i].fd !== exp_q[i].fd) begin
                n_err++;
                $display("[TB] FAIL b2b_win%0d: got %h/%b want %h/%b", i, obs_q[i].win, obs_q[i].fd, exp_q[i].win, exp_q[i].fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_mid_sof();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv1_window_gen.md
# conv1_window_gen

Sliding-window generator directly upstream of `conv1`. It accepts a raster-order pixel stream of 3 channels × 16 bits and buffers two full image lines. For every valid 3×3 position (stride 1, no padding) it emits one 432-bit window per cycle, packed exactly in the layout `conv1` consumes on `input_act`. It drives `conv1.valid` and `conv1.input_act` directly; there is no backpressure.

## Interface
Parameters:
- `IMG_W`, default 16: image width in pixels; must be ≥ 3.
- `IMG_H`, default 16: image height in lines; must be ≥ 3.
- `CH`, default 3: channels per pixel; fixed at 3 for `conv1`.
- `DW`, default 16: bits per channel sample.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rstn`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: `in_pixel` is presented this cycle and is accepted unconditionally.
- `sof`  in  1: start of frame; meaningful only when `in_valid`=1.
- `in_pixel`  in  CH*DW: channel c is at [DW*c +: DW].
- `out_valid`  out  1: `out_window` holds a new window this cycle (one-cycle pulse per window).
- `out_window`  out  9*CH*DW: channel c tap k is at [9*DW*c + DW*k +: DW].
- `frame_done`  out  1: one-cycle pulse coincident with the last window of a frame.

## Operation
State:
- Column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1) give the position of the next pixel to be accepted.
- Line buffers `lb0[IMG_W]` hold line row-1 and `lb1[IMG_W]` hold line row-2, each entry CH*DW wide.
- A 3×3×CH window register array.

Tap numbering and packing:
- k = 3*r + x.
- r = 0 is the top line (row-2); r = 2 is the current line.
- x = 0 is the leftmost column (col-2); x = 2 is the current column.

On each accepted pixel p at (row, col):
- Form the new column {top = lb1[col], mid = lb0[col], bot = p}.
- Write lb1[col] ← lb0[col] and lb0[col] ← p.
- Shift the window left by one column; the new column enters at x = 2.
- Advance `col`. On col = IMG_W-1 wrap `col` to 0 and advance `row`. On (IMG_H-1, IMG_W-1) wrap both to 0.

Window emission:
- A window is emitted iff the accepted pixel has row ≥ 2 and col ≥ 2.
- That gives (IMG_W-2)*(IMG_H-2) windows per frame, in raster order.
- Windows that straddle a line wrap (col < 2) are never emitted.

`sof` handling:
- `in_valid`=1 with `sof`=1: the pixel is treated as (0,0). The counters are forced before the update, so the pixel is processed at (0,0) and the next position is (0,1).
- Mid-frame `sof`: the current frame is abandoned and no further windows from it are emitted. Line-buffer contents are not cleared; stale data is never emitted because row < 2 until two new lines have been accepted.
- `sof` with `in_valid`=0 is ignored.

Other input behaviour:
- `in_valid`=0: all state holds.
- Gaps of any length between pixels are legal.

## Timing
Reset (`rstn`=0), asynchronous:
- `out_valid`=0, `frame_done`=0, `out_window`=0.
- Counters = 0; line buffers and window registers = 0.

Latency and throughput:
- Latency is 1 cycle: a window completed by the pixel accepted in cycle N appears on `out_window` with `out_valid`=1 in cycle N+1.
- Throughput is one window per cycle with back-to-back `in_valid`.

Output hold and pulses:
- `out_window` holds its last emitted value while `out_valid`=0. It updates only together with `out_valid`=1.
- `frame_done`=1 in the same cycle as the `out_valid` for the window at (IMG_H-1, IMG_W-1).

Downstream:
- `conv1` registers the window and its `valid` one cycle later, so the total from pixel to `conv1` ready is 2 cycles plus `conv1`'s own output timing.

## Test plan
Common stimulus: IMG_W=4, IMG_H=4; channel c of pixel (r,x) = 256*c + 4*r + x.

- Full frame, `in_valid` held high after `sof` on the first pixel: exactly 4 `out_valid` pulses, in the cycles after pixels (2,2), (2,3), (3,2), (3,3).
- First window: ch0 taps k0..k8 = 0,1,2,4,5,6,8,9,10; ch2 tap8 = 522. `frame_done` asserts only with the 4th window, whose ch1 taps = 261,262,263,265,266,267,269,270,271.
- Random `in_valid` gaps (~50% duty) over the same frame: identical 4 windows in the same order. `out_window` stable between pulses.
- Mid-frame `sof` asserted at pixel (2,1), then a full new frame: no window is emitted from the aborted frame, and the new frame yields exactly 4 correct windows.
- `rstn` deasserted asynchronously mid-frame (between clock edges): all outputs are 0 immediately. After release, a frame starting with `sof` produces correct windows and `frame_done`.
- Two back-to-back frames, `sof` only on the first: counter wrap alone delivers 8 windows and 2 `frame_done` pulses.
